chacha_core_ctrl: RTL and testbench

- Iterative ChaCha block-function controller. It sequences four instances of the combinational quarter-round (QR) datapath over a 16-word working state: one column or diagonal half-round per clock.
- It accepts a 512-bit initial state over a valid/ready handshake, runs ROUNDS half-rounds, applies the final feed-forward addition and presents the 512-bit keystream block over a valid/ready handshake.
- It sits between the key/nonce/counter front end and the random-output buffer of the RNG.

---
 rtl/chacha_core_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_chacha_core_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_core_ctrl.sv
// rtl/chacha_core_ctrl.sv - iterative ChaCha block controller with four parallel quarter-rounds

module chacha_qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_new,
    output logic [31:0] b_new,
    output logic [31:0] c_new,
    output logic [31:0] d_new
);

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    logic [31:0] a1, b1, c1, d1;
    logic [31:0] a2, b2, c2, d2;

    // add-rotate-xor chain, one full quarter-round in combinational logic
    always_comb begin
        a1 = a + b;
        d1 = rotl(d ^ a1, 16);
        c1 = c + d1;
        b1 = rotl(b ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl(b1 ^ c2, 7);
    end

    assign a_new = a2;
    assign b_new = b2;
    assign c_new = c2;
    assign d_new = d2;

endmodule

module chacha_core_ctrl #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    localparam int CW = 5;

    generate
        if (ROUNDS < 2 || ROUNDS > 30 || (ROUNDS % 2) != 0) begin : g_bad_rounds
            $error("chacha_core_ctrl: ROUNDS must be even and within 2..30");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] round_cnt;
    logic [31:0]   work      [16];
    logic [31:0]   init      [16];
    logic [31:0]   next_work [16];
    logic [127:0]  qa_v;
    logic [127:0]  qb_v;
    logic [127:0]  qc_v;
    logic [127:0]  qd_v;
    logic          odd;

    // odd round counts select the diagonal pattern
    assign odd = round_cnt[0];

    // instance k always owns word k as its 'a'; b/c/d rotate by k+1/k+2/k+3 on diagonals
    generate
        for (genvar k = 0; k < 4; k++) begin : g_qr
            localparam int CB = 4 + k;
            localparam int CC = 8 + k;
            localparam int CD = 12 + k;
            localparam int DB = 4 + ((k + 1) % 4);
            localparam int DC = 8 + ((k + 2) % 4);
            localparam int DD = 12 + ((k + 3) % 4);

            chacha_qr u_qr (
                .a     (work[k]),
                .b     (odd ? work[DB] : work[CB]),
                .c     (odd ? work[DC] : work[CC]),
                .d     (odd ? work[DD] : work[CD]),
                .a_new (qa_v[32*k +: 32]),
                .b_new (qb_v[32*k +: 32]),
                .c_new (qc_v[32*k +: 32]),
                .d_new (qd_v[32*k +: 32])
            );
        end
    endgenerate

    // scatter the four quarter-round results back to the word indices they were read from
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            next_work[i] = work[i];
        end
        for (int k = 0; k < 4; k++) begin
            next_work[k] = qa_v[32*k +: 32];
            if (odd) begin
                next_work[4 + ((k + 1) % 4)]  = qb_v[32*k +: 32];
                next_work[8 + ((k + 2) % 4)]  = qc_v[32*k +: 32];
                next_work[12 + ((k + 3) % 4)] = qd_v[32*k +: 32];
            end else begin
                next_work[4 + k]  = qb_v[32*k +: 32];
                next_work[8 + k]  = qc_v[32*k +: 32];
                next_work[12 + k] = qd_v[32*k +: 32];
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROUND;
            ROUND:   if (round_cnt == CW'(ROUNDS - 1)) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs depend on the state register only
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // working state, round counter and output block registers
    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt <= '0;
            out_valid <= 1'b0;
            out_block <= '0;
            for (int i = 0; i < 16; i++) begin
                work[i] <= '0;
                init[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        round_cnt <= '0;
                        for (int i = 0; i < 16; i++) begin
                            work[i] <= in_state[32*i +: 32];
                            init[i] <= in_state[32*i +: 32];
                        end
                    end
                end
                ROUND: begin
                    round_cnt <= round_cnt + 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        work[i] <= next_work[i];
                    end
                end
                FINAL: begin
                    out_valid <= 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        out_block[32*i +: 32] <= work[i] + init[i];
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_core_ctrl.sv
// tb/tb_chacha_core_ctrl.sv - scoreboard bench for chacha_core_ctrl against a software ChaCha model

module tb_chacha_core_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [511:0] out_block;
    logic         busy;

    logic         in_valid8 = 1'b0;
    logic         in_ready8;
    logic [511:0] in_state8 = '0;
    logic         out_valid8;
    logic         out_ready8 = 1'b1;
    logic [511:0] out_block8;
    logic         busy8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_in  = 0;
    int n_out = 0;
    int last_acc = 0;
    int last_hs  = 0;
    bit rand_ready = 0;

    logic [511:0] exp_q [$];
    int           acc_q [$];
    logic [511:0] exp8_q [$];
    int           acc8_q [$];

    chacha_core_ctrl #(.ROUNDS(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    chacha_core_ctrl #(.ROUNDS(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_state  (in_state8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_block (out_block8),
        .busy      (busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // textbook ChaCha block: double rounds of column then diagonal, then feed-forward
    function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int rounds);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int n = 0; n < rounds; n += 2) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [511:0] rfc_state();
        logic [511:0] s;
        s[31:0]    = 32'h61707865;
        s[63:32]   = 32'h3320646e;
        s[95:64]   = 32'h79622d32;
        s[127:96]  = 32'h6b206574;
        for (int i = 0; i < 8; i++)
            s[128 + 32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        s[415:384] = 32'h00000001;
        s[447:416] = 32'h09000000;
        s[479:448] = 32'h4a000000;
        s[511:480] = 32'h00000000;
        return s;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [511:0] s, input bit keep);
        int n = 0;
        in_state = s;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            timeout("send_accept");
        end else begin
            last_acc = cyc + 1;
            exp_q.push_back(chacha_ref(s, 20));
            acc_q.push_back(cyc + 1);
            n_in++;
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        in_state = rand_state();
    endtask

    task automatic send8(input logic [511:0] s);
        int n = 0;
        in_state8 = s;
        in_valid8 = 1'b1;
        while (!in_ready8 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready8) begin
            timeout("send8_accept");
        end else begin
            exp8_q.push_back(chacha_ref(s, 8));
            acc8_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready && !out_valid && exp8_q.size() == 0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) timeout("drain");
    endtask

    // scoreboard monitor for the 20-round instance
    initial begin
        bit prev_ov = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0) timeout("extra_output_rise");
                    else chk("latency20", 512'(cyc - acc_q.pop_front()), 512'(21));
                end
                if (out_valid && out_ready) begin
                    last_hs = cyc + 1;
                    n_out++;
                    if (exp_q.size() == 0) timeout("unexpected_output");
                    else chk("block20", out_block, exp_q.pop_front());
                end
                prev_ov = out_valid;
            end
        end
    end

    // scoreboard monitor for the 8-round instance
    initial begin
        bit prev_ov8 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov8 = 0;
            end else begin
                if (out_valid8 && !prev_ov8) begin
                    if (acc8_q.size() == 0) timeout("extra_output8");
                    else chk("latency8", 512'(cyc - acc8_q.pop_front()), 512'(9));
                end
                if (out_valid8 && out_ready8) begin
                    if (exp8_q.size() == 0) timeout("unexpected_output8");
                    else chk("block8", out_block8, exp8_q.pop_front());
                end
                prev_ov8 = out_valid8;
            end
        end
    end

    // random consumer backpressure when enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [511:0] a_st;
        logic [511:0] b_st;
        logic [511:0] held;
        int n;
        int acc_a;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_block", out_block, 512'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // RFC 7539 block-function vector
        send(rfc_state(), 0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid) timeout("rfc_out_valid");
        else chk("rfc_words0_3", 512'(out_block[127:0]),
                 512'({32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110}));
        wait_idle();

        // consumer backpressure
        out_ready = 1'b0;
        send(rand_state(), 0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid) timeout("bp_out_valid");
        held = out_block;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 512'(out_valid), 512'(1));
            chk("bp_out_block", out_block, held);
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_busy", 512'(busy), 512'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 512'(out_valid), 512'(0));
        chk("bp_release_ready", 512'(in_ready), 512'(1));
        wait_idle();

        // back-to-back with in_valid held high
        a_st = rand_state();
        b_st = rand_state();
        send(a_st, 1);
        acc_a = last_acc;
        send(b_st, 0);
        chk("b2b_interval", 512'(last_acc - acc_a), 512'(23));
        chk("b2b_after_hs", 512'(last_acc), 512'(last_hs + 1));
        wait_idle();

        // garbage in_valid pulses during ROUND must be ignored
        send(rand_state(), 0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_state = rand_state();
            chk("ignored_in_ready", 512'(in_ready), 512'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (30) @(posedge clk);
        #1;

        // reset in the middle of the rounds (round_cnt = 7)
        send(rand_state(), 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        n_in--;
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        send(rand_state(), 0);
        wait_idle();

        // random states with random consumer backpressure
        rand_ready = 1;
        for (int i = 0; i < 4; i++) send(rand_state(), 0);
        wait_idle();
        rand_ready = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // ChaCha8 build
        send8(rfc_state());
        wait_idle();
        send8('0);
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 512'(exp_q.size()), 512'(0));
        chk("in_out_count", 512'(n_out), 512'(n_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
